// File: rtl/sys_array_result_streamer_pkg.sv
// sys_array_pkg: shared state type and index width for the systolic-array result path
package sys_array_pkg;
    localparam int IDX_W = 16;
    typedef enum logic {IDLE, STREAM} state_t;
endpackage

// File: rtl/sys_array_result_streamer_if.sv
// sys_array_result_streamer_if: valid/ready element stream carrying raw and requantised results
interface sys_array_result_streamer_if
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = 8
);
    logic                           m_valid;
    logic                           m_ready;
    logic                           m_last;
    logic signed [2*DATA_WIDTH-1:0] m_data;
    logic signed [DATA_WIDTH-1:0]   m_q;
    logic [IDX_W-1:0]               m_row;
    logic [IDX_W-1:0]               m_col;
    modport master (output m_valid, m_data, m_q, m_row, m_col, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_q, m_row, m_col, m_last, output m_ready);
endinterface

// File: rtl/sys_array_result_streamer_requant_sat.sv
// requant_sat: round-half-up arithmetic right shift of an accumulator, saturated to DATA_WIDTH
module requant_sat #(
    parameter int DATA_WIDTH = 8
) (
    input  logic signed [2*DATA_WIDTH-1:0] x,
    input  logic [3:0]                     shift,
    output logic signed [DATA_WIDTH-1:0]   q
);
    localparam int W = 2*DATA_WIDTH+1;
    localparam logic signed [W-1:0] MAX = W'((1 << (DATA_WIDTH-1)) - 1);
    localparam logic signed [W-1:0] MIN = ~MAX;
    logic signed [W-1:0] w_x, w_r, w_s;
    // one guard bit keeps x + rounding term from wrapping at the accumulator maximum
    always_comb begin
        w_x = W'(x);
        w_r = (shift == 4'd0) ? '0 : W'(1) << (shift - 4'd1);
        w_s = (w_x + w_r) >>> shift;
        q   = (w_s > MAX) ? MAX[DATA_WIDTH-1:0] : (w_s < MIN) ? MIN[DATA_WIDTH-1:0] : w_s[DATA_WIDTH-1:0];
    end
endmodule

// File: rtl/sys_array_result_streamer.sv
// sys_array_result_streamer: captures a result matrix on comp_ready rising and streams it row-major
module sys_array_result_streamer
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_A_W  = 5,
    parameter int ARRAY_W_L  = 5
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           comp_ready,
    input  logic signed [2*DATA_WIDTH-1:0] out_data [0:ARRAY_A_W-1][0:ARRAY_W_L-1],
    input  logic [3:0]                     quant_shift,
    sys_array_result_streamer_if.master    m,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           overrun
);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ARRAY_A_W-1);
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(ARRAY_W_L-1);
    state_t                         r_state, w_next;
    logic                           r_prev_rdy, r_frame_done, r_overrun;
    logic signed [2*DATA_WIDTH-1:0] r_buf [0:ARRAY_A_W-1][0:ARRAY_W_L-1];
    logic [3:0]                     r_shift;
    logic [IDX_W-1:0]               r_row, r_col;
    logic                           w_trig, w_hs, w_last;
    logic signed [2*DATA_WIDTH-1:0] w_data;
    logic signed [DATA_WIDTH-1:0]   w_q;
    assign w_trig = comp_ready & ~r_prev_rdy;
    assign w_last = (r_row == LAST_ROW) && (r_col == LAST_COL);
    assign w_hs   = (r_state == STREAM) && m.m_ready;
    always_comb begin
        w_next = (r_state == IDLE) ? (w_trig ? STREAM : IDLE) : ((w_hs && w_last) ? IDLE : STREAM);
    end
    always_ff @(posedge clk) begin
        r_state <= !reset_n ? IDLE : w_next;
    end
    // coordinates wrap fully to (0,0) after the final element so idle outputs sit at the origin
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prev_rdy   <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_shift      <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_buf        <= '{default: '0};
        end else begin
            r_prev_rdy   <= comp_ready;
            r_frame_done <= w_hs && w_last;
            r_overrun    <= r_overrun | (w_trig && r_state == STREAM);
            if (r_state == IDLE && w_trig) begin
                r_buf   <= out_data;
                r_shift <= quant_shift;
                r_row   <= '0;
                r_col   <= '0;
            end else if (w_hs) begin
                r_col <= (r_col == LAST_COL) ? '0 : r_col + 1'b1;
                r_row <= w_last ? '0 : (r_col == LAST_COL) ? r_row + 1'b1 : r_row;
            end
        end
    end
    always_comb begin
        w_data = '0;
        for (int i = 0; i < ARRAY_A_W; i++)
            for (int j = 0; j < ARRAY_W_L; j++)
                if (r_row == IDX_W'(i) && r_col == IDX_W'(j)) w_data = r_buf[i][j];
    end
    requant_sat #(.DATA_WIDTH(DATA_WIDTH)) u_requant (
        .x     (w_data),
        .shift (r_shift),
        .q     (w_q)
    );
    assign m.m_valid  = r_state == STREAM;
    assign m.m_data   = w_data;
    assign m.m_q      = w_q;
    assign m.m_row    = r_row;
    assign m.m_col    = r_col;
    assign m.m_last   = w_last;
    assign busy       = r_state == STREAM;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;
endmodule

// File: tb/tb_sys_array_result_streamer.sv
// tb_sys_array_result_streamer: directed checks of capture, streaming, stalls, requantisation, overrun and reset
module tb_sys_array_result_streamer;
    localparam int DW = 8;
    localparam int A  = 2;
    localparam int W  = 3;
    localparam int N  = A*W;
    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   comp_ready;
    logic [3:0]             quant_shift;
    logic signed [2*DW-1:0] out_data [0:A-1][0:W-1];
    logic                   busy, frame_done, overrun;
    int                     n_checks = 0;
    int                     n_fail = 0;
    int                     e_d [N];
    int                     e_q [N];
    sys_array_result_streamer_if #(.DATA_WIDTH(DW)) s();
    sys_array_result_streamer #(.DATA_WIDTH(DW), .ARRAY_A_W(A), .ARRAY_W_L(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .comp_ready  (comp_ready),
        .out_data    (out_data),
        .quant_shift (quant_shift),
        .m           (s),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic apply();
        for (int i = 0; i < A; i++)
            for (int j = 0; j < W; j++)
                out_data[i][j] = 16'(e_d[i*W+j]);
    endtask
    task automatic trigger();
        comp_ready = 1'b0;
        @(negedge clk);
        comp_ready = 1'b1;
    endtask
    // mode 0: ready held high; 1: ready 1,0,0 pattern; 2: second comp_ready edge mid-frame; 3: corrupt live inputs after capture
    task automatic run_frame(input int mode);
        int idx = 0;
        for (int c = 0; c < 40 && idx < N; c++) begin
            @(negedge clk);
            if (mode == 3 && c == 0) begin
                for (int i = 0; i < A; i++)
                    for (int j = 0; j < W; j++)
                        out_data[i][j] = 16'sd99;
                quant_shift = 4'd7;
            end
            if (mode == 2 && c == 2) comp_ready = 1'b0;
            if (mode == 2 && c == 3) comp_ready = 1'b1;
            check("valid", int'(s.m_valid), 1);
            check("data", int'(s.m_data), e_d[idx]);
            check("q", int'(s.m_q), e_q[idx]);
            check("row", int'(s.m_row), idx / W);
            check("col", int'(s.m_col), idx % W);
            check("last", int'(s.m_last), int'(idx == N-1));
            check("busy", int'(busy), 1);
            s.m_ready = (mode != 1) || (c % 3 == 0);
            if (s.m_ready && s.m_valid) idx++;
        end
        check("count", idx, N);
        @(negedge clk);
        check("frame_done", int'(frame_done), 1);
        check("valid_end", int'(s.m_valid), 0);
        check("busy_end", int'(busy), 0);
        @(negedge clk);
        check("done_pulse", int'(frame_done), 0);
        check("no_restart", int'(s.m_valid), 0);
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        reset_n     = 1'b0;
        comp_ready  = 1'b0;
        quant_shift = 4'd0;
        s.m_ready   = 1'b0;
        e_d = '{0, 0, 0, 0, 0, 0};
        apply();
        repeat (2) @(negedge clk);
        check("rst_valid", int'(s.m_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_last", int'(s.m_last), 0);
        check("rst_data", int'(s.m_data), 0);
        check("rst_q", int'(s.m_q), 0);
        check("rst_row", int'(s.m_row), 0);
        check("rst_col", int'(s.m_col), 0);
        // basic frame, triggered on the first cycle after reset release
        e_d = '{1, 2, 3, 4, 5, 6};
        e_q = '{1, 2, 3, 4, 5, 6};
        apply();
        reset_n    = 1'b1;
        comp_ready = 1'b1;
        run_frame(3);
        // stalls plus rounding and saturation
        e_d = '{300, -300, 7, 8, -9, 1000};
        e_q = '{75, -75, 2, 2, -2, 127};
        quant_shift = 4'd2;
        apply();
        trigger();
        run_frame(1);
        // comp_ready held high: one frame only; shift 0 saturation at both rails
        e_d = '{32767, -32768, 128, -129, 127, -128};
        e_q = '{127, -128, 127, -128, 127, -128};
        quant_shift = 4'd0;
        apply();
        trigger();
        run_frame(0);
        repeat (12) begin
            @(negedge clk);
            check("hold_valid", int'(s.m_valid), 0);
        end
        check("overrun_clear", int'(overrun), 0);
        // retrigger mid-frame at maximum shift
        e_d = '{16384, -16384, 16383, -16385, 32767, -32768};
        e_q = '{1, 0, 0, -1, 1, -1};
        quant_shift = 4'd15;
        apply();
        trigger();
        run_frame(2);
        check("overrun_set", int'(overrun), 1);
        // reset after the third handshake
        trigger();
        s.m_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_rst_row", int'(s.m_row), 1);
        check("pre_rst_col", int'(s.m_col), 0);
        check("pre_rst_valid", int'(s.m_valid), 1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n    = 1'b1;
        comp_ready = 1'b0;
        check("abort_valid", int'(s.m_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_overrun", int'(overrun), 0);
        check("abort_row", int'(s.m_row), 0);
        check("abort_col", int'(s.m_col), 0);
        check("abort_data", int'(s.m_data), 0);
        @(negedge clk);
        check("idle_after_rst", int'(s.m_valid), 0);
        e_d = '{5, -5, 3, -3, 255, -256};
        e_q = '{3, -2, 2, -1, 127, -128};
        quant_shift = 4'd1;
        apply();
        trigger();
        run_frame(0);
        check("overrun_final", int'(overrun), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
